// File: rtl/psum_out_drain_pkg.sv
// Shared definitions for the psum output drain stage.
// Holds the drain FSM encoding and the default beat width.
package psum_out_drain_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } drain_state_t;

    localparam int OUT_BW_DEFAULT = 32;

endpackage

// File: rtl/psum_out_drain_fifo.sv
// Vector FIFO for the drain stage: depth entries of one full psum vector.
// Push/pop arrive pre-qualified from the drain control.
module psum_vec_fifo
    import psum_out_drain_pkg::*;
#(
    parameter int depth = 4,
    parameter int width = 128,
    localparam int PTR_W = $clog2(depth),
    localparam int CNT_W = $clog2(depth) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [width-1:0] wr_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic [width-1:0] head
);

    logic [width-1:0] mem_q [depth];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is only observed while non-empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign full  = (count_q == CNT_W'(depth));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/psum_out_drain.sv
// Drains 128-bit core output vectors through a FIFO into narrow beats.
// Core cannot stall, so vectors arriving to a full FIFO are dropped.
module psum_out_drain
    import psum_out_drain_pkg::*;
#(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int out_bw  = OUT_BW_DEFAULT,
    parameter int depth   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [psum_bw*col-1:0] in_data,
    input  logic                   clear,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [out_bw-1:0]      out_data,
    output logic                   out_last,
    output logic                   overflow,
    output logic [15:0]            vec_count
);

    localparam int VEC_W  = psum_bw * col;
    localparam int BEATS  = VEC_W / out_bw;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CNT_W  = $clog2(depth) + 1;

    if ((VEC_W % out_bw) != 0) begin : g_bad_width
        $error("psum_bw*col must be a multiple of out_bw");
    end
    if ((depth < 2) || ((depth & (depth - 1)) != 0)) begin : g_bad_depth
        $error("depth must be a power of two and at least 2");
    end

    drain_state_t      state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              overflow_q, overflow_d;
    logic [15:0]       vec_count_q, vec_count_d;

    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [VEC_W-1:0]  fifo_head;

    logic              xfer;
    logic              at_last;
    logic              last_pop;
    logic              push;
    logic [out_bw-1:0] beat_word;

    assign at_last  = (beat_q == BEAT_W'(BEATS - 1));
    assign xfer     = out_valid & out_ready;
    assign last_pop = xfer & at_last;
    // A pop in the same cycle frees the slot a full FIFO needs.
    assign push     = in_valid & (~fifo_full | last_pop);

    psum_vec_fifo #(
        .depth (depth),
        .width (VEC_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (last_pop),
        .wr_data (in_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count),
        .head    (fifo_head)
    );

    always_comb begin
        beat_word = '0;
        for (int b = 0; b < BEATS; b++) begin
            if (beat_q == BEAT_W'(b)) begin
                beat_word = fifo_head[out_bw*b +: out_bw];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        overflow_d  = overflow_q;
        vec_count_d = vec_count_q;

        unique case (state_q)
            ST_IDLE: begin
                if (push) begin
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (last_pop && fifo_count == CNT_W'(1) && !push) begin
                    state_d = ST_IDLE;
                end
            end
        endcase

        if (xfer) begin
            beat_d = at_last ? '0 : beat_q + BEAT_W'(1);
        end

        if (clear) begin
            overflow_d  = 1'b0;
            vec_count_d = '0;
        end else begin
            if (in_valid && !push) begin
                overflow_d = 1'b1;
            end
            if (last_pop) begin
                vec_count_d = vec_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            beat_q      <= '0;
            overflow_q  <= 1'b0;
            vec_count_q <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            overflow_q  <= overflow_d;
            vec_count_q <= vec_count_d;
        end
    end

    assign out_valid = (state_q == ST_STREAM);
    assign out_last  = out_valid & at_last;
    assign out_data  = out_valid ? beat_word : '0;
    assign overflow  = overflow_q;
    assign vec_count = vec_count_q;

    logic unused_empty;
    assign unused_empty = fifo_empty;

endmodule

// File: tb/tb_psum_out_drain.sv
// Randomized bench for psum_out_drain against a beat-queue reference model.
// Directed scenarios plus a random soak, all checked through chk().
module tb_psum_out_drain;

    localparam int BEATS = 4;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic [127:0] in_data;
    logic         clear;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic         out_last;
    logic         overflow;
    logic [15:0]  vec_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] bq[$];
    bit          lq[$];
    bit          exp_ovf;
    logic [15:0] exp_cnt;

    always #5 clk = ~clk;

    psum_out_drain dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .clear     (clear),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .overflow  (overflow),
        .vec_count (vec_count)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        bq.delete();
        lq.delete();
        exp_ovf = 1'b0;
        exp_cnt = '0;
    endtask

    task automatic check_all(input string tag);
        logic [31:0] ed;
        bit          el;
        ed = 32'h0;
        el = 1'b0;
        if (bq.size() != 0) begin
            ed = bq[0];
            el = lq[0];
        end
        chk({tag, ".valid"}, 32'(out_valid), 32'(bq.size() != 0));
        chk({tag, ".data"}, out_data, ed);
        chk({tag, ".last"}, 32'(out_last), 32'(el));
        chk({tag, ".ovf"}, 32'(overflow), 32'(exp_ovf));
        chk({tag, ".cnt"}, 32'(vec_count), 32'(exp_cnt));
    endtask

    // Drive one cycle of inputs, advance the model, check after the edge.
    task automatic step(input string tag, input logic iv,
                        input logic [127:0] id, input logic rdy,
                        input logic clr);
        bit hs, lhs, acc;
        int nvec;
        in_valid  = iv;
        in_data   = id;
        out_ready = rdy;
        clear     = clr;
        hs   = (bq.size() != 0) && rdy;
        lhs  = hs && lq[0];
        nvec = (bq.size() + BEATS - 1) / BEATS;
        acc  = iv && ((nvec < DEPTH) || lhs);
        if (hs) begin
            void'(bq.pop_front());
            void'(lq.pop_front());
        end
        if (acc) begin
            for (int b = 0; b < BEATS; b++) begin
                bq.push_back(id[32*b +: 32]);
                lq.push_back(b == BEATS - 1);
            end
        end
        if (clr) begin
            exp_ovf = 1'b0;
            exp_cnt = '0;
        end else begin
            if (iv && !acc) exp_ovf = 1'b1;
            if (lhs) exp_cnt = exp_cnt + 16'd1;
        end
        @(posedge clk);
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic drain(input string tag);
        int guard = 0;
        while (bq.size() != 0 && guard < 100) begin
            step(tag, 1'b0, '0, 1'b1, 1'b0);
            guard++;
        end
        chk({tag, ".drained"}, 32'(out_valid), 32'h0);
    endtask

    logic [127:0] vec;
    logic [127:0] rv;
    int           nbeats;

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        clear     = 1'b0;
        out_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        reset = 1'b0;
        @(negedge clk);

        vec = 128'h0007_0006_0005_0004_0003_0002_0001_0000;
        step("single", 1'b1, vec, 1'b1, 1'b0);
        chk("single.b0", out_data, 32'h00010000);
        step("single", 1'b0, '0, 1'b1, 1'b0);
        chk("single.b1", out_data, 32'h00030002);
        step("single", 1'b0, '0, 1'b1, 1'b0);
        chk("single.b2", out_data, 32'h00050004);
        step("single", 1'b0, '0, 1'b1, 1'b0);
        chk("single.b3", out_data, 32'h00070006);
        chk("single.last", 32'(out_last), 32'h1);
        step("single", 1'b0, '0, 1'b1, 1'b0);
        chk("single.cnt", 32'(vec_count), 32'h1);

        step("bp", 1'b1, vec, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) begin
            step("bp", 1'b0, '0, (i % 3) == 2, 1'b0);
        end
        drain("bp");
        chk("bp.cnt", 32'(vec_count), 32'h2);

        for (int i = 0; i < 5; i++) begin
            rv = {$urandom(), $urandom(), $urandom(), $urandom()};
            step("ovf_fill", 1'b1, rv, 1'b0, 1'b0);
        end
        chk("ovf.flag", 32'(overflow), 32'h1);
        nbeats = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) nbeats++;
            step("ovf_drain", 1'b0, '0, 1'b1, 1'b0);
        end
        chk("ovf.beats", 32'(nbeats), 32'd16);
        step("ovf_clr", 1'b0, '0, 1'b0, 1'b1);
        chk("ovf.cleared", 32'(overflow), 32'h0);

        for (int i = 0; i < 4; i++) begin
            rv = {$urandom(), $urandom(), $urandom(), $urandom()};
            step("full_fill", 1'b1, rv, 1'b0, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            step("full_adv", 1'b0, '0, 1'b1, 1'b0);
        end
        chk("full.at_last", 32'(out_last), 32'h1);
        rv = {$urandom(), $urandom(), $urandom(), $urandom()};
        step("full_pop", 1'b1, rv, 1'b1, 1'b0);
        chk("full.no_ovf", 32'(overflow), 32'h0);
        drain("full_drain");

        step("rst_mid", 1'b1, vec, 1'b1, 1'b0);
        step("rst_mid", 1'b0, '0, 1'b1, 1'b0);
        step("rst_mid", 1'b0, '0, 1'b1, 1'b0);
        in_valid = 1'b0;
        #1 reset = 1'b1;
        model_reset();
        #1;
        chk("rst_mid.valid", 32'(out_valid), 32'h0);
        chk("rst_mid.cnt", 32'(vec_count), 32'h0);
        chk("rst_mid.data", out_data, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        step("rst_after", 1'b1, vec, 1'b1, 1'b0);
        chk("rst_after.b0", out_data, 32'h00010000);
        drain("rst_after");

        for (int i = 0; i < 3000; i++) begin
            rv = {$urandom(), $urandom(), $urandom(), $urandom()};
            step("rand", 1'($urandom_range(0, 1)), rv,
                 $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0);
        end
        drain("rand_drain");

        in_valid = 1'b0;
        clear    = 1'b0;
        force dut.vec_count_q = 16'hFFFF;
        @(posedge clk);
        @(negedge clk);
        release dut.vec_count_q;
        exp_cnt = 16'hFFFF;
        step("wrap_pre", 1'b0, '0, 1'b0, 1'b0);
        step("wrap", 1'b1, vec, 1'b1, 1'b0);
        drain("wrap");
        chk("wrap.cnt", 32'(vec_count), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
